instr_prefetch_queue: RTL

Instruction fetch front end that sits directly upstream of the single-cycle core's decode path. It replaces the combinational PC → instruction-memory lookup with a sequential fetcher. The fetcher issues sequential word fetches to a variable-latency instruction memory and buffers returned instructions with their PCs in a small in-order FIFO. It presents them to decode over a valid/ready handshake and flushes cleanly on a PC redirect.

---
 rtl/instr_prefetch_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction fetcher. Issues credit-limited word fetches, buffers
// {pc, instr} in order, and drops in-flight responses after a redirect.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [31:0]            mem_rdata_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   instr_valid_o,
  output logic [31:0]            instr_o,
  output logic [31:0]            instr_pc_o,
  input  logic                   instr_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [AW:0]   r_out, r_disc, r_count;
  logic [AW-1:0] r_wr, r_rd, r_twr, r_trd;
  logic [31:0]   r_tag   [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_ipc   [DEPTH];

  logic          w_gnt, w_keep, w_drop, w_push, w_pop;
  logic [AW+1:0] w_credit;
  logic [AW:0]   w_disc_redir, w_disc_nxt;

  // Buffered plus in-flight never exceeds DEPTH, so a response always has room.
  assign w_credit   = {1'b0, r_count} + {1'b0, r_out};
  assign mem_req_o  = (r_state == RUN) & start_i & ~redirect_i & (w_credit < (AW+2)'(DEPTH));
  assign mem_addr_o = r_fetch_pc;
  assign w_gnt      = mem_req_o & mem_gnt_i;
  assign w_drop     = mem_rvalid_i & (r_disc != '0);
  assign w_keep     = mem_rvalid_i & (r_disc == '0);
  assign w_push     = w_keep & ~redirect_i;
  assign w_pop      = instr_valid_o & instr_ready_i;

  assign w_disc_redir = r_disc + r_out + (AW+1)'(w_gnt) - (AW+1)'(mem_rvalid_i);
  assign w_disc_nxt   = redirect_i ? w_disc_redir : r_disc - (AW+1)'(w_drop);

  assign instr_valid_o = (r_count != '0);
  assign instr_o       = r_instr[r_rd];
  assign instr_pc_o    = r_ipc[r_rd];
  assign count_o       = r_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_disc     <= '0;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_twr      <= '0;
      r_trd      <= '0;
    end else begin
      r_disc <= w_disc_nxt;
      unique case (r_state)
        IDLE:    if (redirect_i && w_disc_nxt != '0) r_state <= FLUSH;
                 else if (start_i)                   r_state <= RUN;
        RUN:     if (redirect_i) r_state <= (w_disc_nxt != '0) ? FLUSH : RUN;
                 else if (!start_i) r_state <= IDLE;
        FLUSH:   if (w_disc_nxt == '0) r_state <= start_i ? RUN : IDLE;
        default: r_state <= IDLE;
      endcase
      if (redirect_i) begin
        r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        r_out      <= '0;
        r_count    <= '0;
        r_wr       <= '0;
        r_rd       <= '0;
        r_twr      <= '0;
        r_trd      <= '0;
      end else begin
        if (w_gnt) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_twr      <= r_twr + AW'(1);
        end
        if (w_keep) r_trd <= r_trd + AW'(1);
        if (w_push) r_wr  <= r_wr + AW'(1);
        if (w_pop)  r_rd  <= r_rd + AW'(1);
        r_out   <= r_out + (AW+1)'(w_gnt) - (AW+1)'(w_keep);
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_ipc[i]   <= '0;
      end
    end else if (w_push) begin
      r_instr[r_wr] <= mem_rdata_i;
      r_ipc[r_wr]   <= r_tag[r_trd];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_gnt) r_tag[r_twr] <= r_fetch_pc;
  end
endmodule
